calc_param: RTL and testbench

Parametrised successor to the single-width calculator. It accepts a stream of 4-bit keypad commands: decimal digits, add/sub/mul/div, equals and backspace. Arithmetic runs on unsigned operands of up to DIGITS decimal digits. After every accepted command the current value is serialised one BCD digit per cycle to the seven-segment driver. It sits between the keypad scanner and the multiplexed display, with a valid/ready-style handshake on the command side.

---
 rtl/calc_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_calc_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_param.sv
// rtl/calc_param.sv - keypad-driven decimal calculator with serial BCD display output
module calc_param #(
    parameter int DIGITS = 8,
    parameter int W      = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cmd,
    input  logic       cmd_valid,
    output logic [1:0] status,
    output logic [3:0] data,
    output logic [3:0] pos,
    output logic       data_valid,
    output logic       neg
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [W-1:0] MAX_W = W'(pow10(DIGITS) - 64'd1);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;
    localparam logic [3:0] EQ     = 4'hE;
    localparam logic [3:0] BS     = 4'hF;

    typedef enum logic [3:0] {
        ENTRY_A, ENTRY_B, APPLY, EXEC, MUL, DIV, CONV, PRINT, ERROR
    } state_t;

    state_t              state;
    logic [W-1:0]        acc, reg_a, reg_b, quo, rem, bin;
    logic [3:0]          op, cmd_reg;
    logic                fresh, in_b, ret_b;
    logic [CW-1:0]       cnt;
    logic [2*W-1:0]      prod;
    logic [4*DIGITS-1:0] bcd;

    logic [W+3:0]        dig_ext;
    logic                dig_ok, div_ge, mul_over;
    logic [W-1:0]        acc_div10, rem_next, quo_next, src_bin, bin_next;
    logic [W:0]          add_sum, mul_sum, div_trial, div_diff;
    logic [2*W-1:0]      prod_next;
    logic [4*DIGITS-1:0] src_bcd, adj, bcd_next;

    // Datapath helpers: digit append, backspace, one shift-add / restoring-divide / double-dabble step
    always_comb begin
        dig_ext   = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{W{1'b0}}, cmd_reg};
        dig_ok    = (dig_ext[W+3:W] == 4'd0) && (dig_ext[W-1:0] <= MAX_W);
        acc_div10 = acc / W'(10);
        add_sum   = {1'b0, reg_a} + {1'b0, reg_b};
        mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, reg_b};
        prod_next = prod[0] ? {mul_sum, prod[W-1:1]} : {1'b0, prod[2*W-1:1]};
        mul_over  = (prod_next[2*W-1:W] != '0) || (prod_next[W-1:0] > MAX_W);
        div_trial = {rem, quo[W-1]};
        div_ge    = div_trial >= {1'b0, reg_b};
        div_diff  = div_trial - {1'b0, reg_b};
        rem_next  = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
        quo_next  = {quo[W-2:0], div_ge};
        src_bcd   = (cnt == '0) ? '0 : bcd;
        src_bin   = (cnt == '0) ? acc : bin;
        adj       = src_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (src_bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = src_bcd[4*i +: 4] + 4'd3;
        end
        bcd_next  = {adj[4*DIGITS-2:0], src_bin[W-1]};
        bin_next  = {src_bin[W-2:0], 1'b0};
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ENTRY_A;
            acc        <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            op         <= '0;
            fresh      <= 1'b0;
            cmd_reg    <= '0;
            in_b       <= 1'b0;
            ret_b      <= 1'b0;
            cnt        <= '0;
            prod       <= '0;
            quo        <= '0;
            rem        <= '0;
            bin        <= '0;
            bcd        <= '0;
            status     <= ST_READY;
            data       <= '0;
            pos        <= '0;
            data_valid <= 1'b0;
            neg        <= 1'b0;
        end else begin
            case (state)
                ENTRY_A, ENTRY_B: begin
                    if (cmd_valid) begin
                        cmd_reg <= cmd;
                        in_b    <= (state == ENTRY_B);
                        neg     <= 1'b0;
                        status  <= ST_BUSY;
                        state   <= APPLY;
                    end
                end
                APPLY: begin
                    cnt <= '0;
                    if (cmd_reg <= 4'd9) begin
                        if (!in_b && fresh) begin
                            acc   <= W'(cmd_reg);
                            fresh <= 1'b0;
                        end else if (dig_ok) begin
                            acc <= dig_ext[W-1:0];
                        end
                        ret_b <= in_b;
                        state <= CONV;
                    end else if (cmd_reg == BS) begin
                        acc   <= acc_div10;
                        if (!in_b) fresh <= 1'b0;
                        ret_b <= in_b;
                        state <= CONV;
                    end else if (cmd_reg == EQ) begin
                        if (in_b) begin
                            reg_b <= acc;
                            state <= EXEC;
                        end else begin
                            ret_b <= 1'b0;
                            state <= CONV;
                        end
                    end else if (in_b) begin
                        // a second operator while entering the right operand is illegal
                        status <= ST_ERR;
                        data   <= '0;
                        pos    <= '0;
                        state  <= ERROR;
                    end else begin
                        reg_a <= acc;
                        op    <= cmd_reg;
                        acc   <= '0;
                        ret_b <= 1'b1;
                        state <= CONV;
                    end
                end
                EXEC: begin
                    cnt <= '0;
                    if (op == OP_ADD) begin
                        if (add_sum[W] || (add_sum[W-1:0] > MAX_W)) begin
                            status <= ST_ERR;
                            data   <= '0;
                            pos    <= '0;
                            state  <= ERROR;
                        end else begin
                            acc   <= add_sum[W-1:0];
                            fresh <= 1'b1;
                            ret_b <= 1'b0;
                            state <= CONV;
                        end
                    end else if (op == OP_SUB) begin
                        if (reg_a >= reg_b) begin
                            acc <= reg_a - reg_b;
                        end else begin
                            acc <= reg_b - reg_a;
                            neg <= 1'b1;
                        end
                        fresh <= 1'b1;
                        ret_b <= 1'b0;
                        state <= CONV;
                    end else if (op == OP_MUL) begin
                        prod  <= {{W{1'b0}}, reg_a};
                        state <= MUL;
                    end else if (reg_b == '0) begin
                        status <= ST_ERR;
                        data   <= '0;
                        pos    <= '0;
                        state  <= ERROR;
                    end else begin
                        quo   <= reg_a;
                        rem   <= '0;
                        state <= DIV;
                    end
                end
                MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        cnt <= '0;
                        if (mul_over) begin
                            status <= ST_ERR;
                            data   <= '0;
                            pos    <= '0;
                            state  <= ERROR;
                        end else begin
                            acc   <= prod_next[W-1:0];
                            fresh <= 1'b1;
                            ret_b <= 1'b0;
                            state <= CONV;
                        end
                    end
                end
                DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        cnt   <= '0;
                        acc   <= quo_next;
                        fresh <= 1'b1;
                        ret_b <= 1'b0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    // first step loads acc directly so no separate load cycle is spent
                    bcd <= bcd_next;
                    bin <= bin_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        cnt   <= '0;
                        state <= PRINT;
                    end
                end
                PRINT: begin
                    if (cnt == CW'(DIGITS)) begin
                        data_valid <= 1'b0;
                        pos        <= '0;
                        status     <= ST_READY;
                        cnt        <= '0;
                        state      <= ret_b ? ENTRY_B : ENTRY_A;
                    end else begin
                        data       <= bcd[3:0];
                        bcd        <= bcd >> 4;
                        pos        <= 4'(cnt);
                        data_valid <= 1'b1;
                        cnt        <= cnt + 1'b1;
                    end
                end
                ERROR: begin
                    status     <= ST_ERR;
                    data       <= '0;
                    pos        <= '0;
                    data_valid <= 1'b0;
                end
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_param.sv
// tb/tb_calc_param.sv - scoreboard bench for calc_param
module tb_calc_param;
    localparam int DIGITS = 8;
    localparam int W      = 27;
    localparam int T_KEY  = W + DIGITS + 2;
    localparam int T_ADD  = W + DIGITS + 3;
    localparam int T_MUL  = 2 * W + DIGITS + 3;

    localparam logic [3:0] K_ADD = 4'hA, K_SUB = 4'hB, K_MUL = 4'hC, K_DIV = 4'hD;
    localparam logic [3:0] K_EQ  = 4'hE, K_BS  = 4'hF;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic       data_valid;
    logic       neg;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    calc_param #(.DIGITS(DIGITS), .W(W)) dut (
        .clock(clock), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .status(status), .data(data), .pos(pos), .data_valid(data_valid), .neg(neg)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // scoreboard consumer: every emitted digit is matched against the queue
    always @(negedge clock) begin
        if (reset && data_valid) begin
            if (exp_q.size() == 0) begin
                chk("extra_digit", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pos", 64'(pos), 64'(e[7:4]));
                chk("data", 64'(data), 64'(e[3:0]));
            end
        end
    end

    task automatic expect_val(input longint v);
        longint t = v;
        for (int i = 0; i < DIGITS; i++) begin
            exp_q.push_back({4'(i), 4'(t % 10)});
            t = t / 10;
        end
    endtask

    task automatic accept(input logic [3:0] c);
        int n = 0;
        @(negedge clock);
        while (status !== 2'b10 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_cmd", 64'(status), 64'(2'b10));
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int exp_n, input logic [1:0] exp_st);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (status == 2'b01 && n < 300);
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_n));
        chk({tag, "_status"}, 64'(status), 64'(exp_st));
        @(negedge clock);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic step(input logic [3:0] c, input longint v, input int t);
        expect_val(v);
        accept(c);
        finish_cmd($sformatf("cmd%0h_v%0d", c, v), t, 2'b10);
    endtask

    task automatic enter(input longint v);
        longint t = v;
        longint run = 0;
        int d[$];
        do begin
            d.push_front(int'(t % 10));
            t = t / 10;
        end while (t != 0);
        foreach (d[i]) begin
            run = run * 10 + d[i];
            step(4'(d[i]), run, T_KEY);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_status"}, 64'(status), 64'(2'b10));
        chk({tag, "_valid"}, 64'(data_valid), 64'd0);
        chk({tag, "_data"}, 64'(data), 64'd0);
        chk({tag, "_pos"}, 64'(pos), 64'd0);
        chk({tag, "_neg"}, 64'(neg), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check_idle_outputs("reset");

        // 1,2,3 with a command dropped while busy
        step(4'd1, 1, T_KEY);
        step(4'd2, 12, T_KEY);
        expect_val(123);
        accept(4'd3);
        @(negedge clock);
        cmd = 4'd5;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clock);
        cmd_valid = 1'b0;
        finish_cmd("busy_drop", T_KEY, 2'b10);

        // 45 + 78 = 123, then fresh replace
        do_reset();
        enter(45);
        step(K_ADD, 0, T_KEY);
        enter(78);
        step(K_EQ, 123, T_ADD);
        chk("add_neg", 64'(neg), 64'd0);
        step(4'd9, 9, T_KEY);

        // 12 - 30 = -18
        do_reset();
        enter(12);
        step(K_SUB, 0, T_KEY);
        enter(30);
        step(K_EQ, 18, T_ADD);
        chk("sub_neg", 64'(neg), 64'd1);
        step(4'd4, 4, T_KEY);
        chk("sub_neg_clear", 64'(neg), 64'd0);

        // 1234 * 5678
        do_reset();
        enter(1234);
        step(K_MUL, 0, T_KEY);
        enter(5678);
        step(K_EQ, 7006652, T_MUL);

        // multiply overflow is sticky
        do_reset();
        enter(99999999);
        step(K_MUL, 0, T_KEY);
        step(4'd2, 2, T_KEY);
        accept(K_EQ);
        finish_cmd("mul_ovf", 2 + W, 2'b00);
        cmd = 4'd1;
        cmd_valid = 1'b1;
        repeat (60) @(negedge clock);
        cmd_valid = 1'b0;
        chk("err_sticky_status", 64'(status), 64'd0);
        chk("err_sticky_valid", 64'(data_valid), 64'd0);
        chk("err_sticky_data", 64'(data), 64'd0);

        // 100 / 7, then divide by zero
        do_reset();
        enter(100);
        step(K_DIV, 0, T_KEY);
        step(4'd7, 7, T_KEY);
        step(K_EQ, 14, T_MUL);
        do_reset();
        step(4'd5, 5, T_KEY);
        step(K_DIV, 0, T_KEY);
        step(4'd0, 0, T_KEY);
        accept(K_EQ);
        finish_cmd("div0", 2, 2'b00);

        // digit overflow, backspace, illegal op in ENTRY_B
        do_reset();
        enter(12345678);
        step(4'd9, 12345678, T_KEY);
        step(K_BS, 1234567, T_KEY);
        step(K_ADD, 0, T_KEY);
        accept(K_SUB);
        finish_cmd("illegal_op", 1, 2'b00);

        // reset pulse in the middle of a multiply
        do_reset();
        step(4'd3, 3, T_KEY);
        step(K_MUL, 0, T_KEY);
        step(4'd4, 4, T_KEY);
        accept(K_EQ);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_idle_outputs("mid_mul_reset");
        @(negedge clock);
        reset = 1'b1;
        step(4'd7, 7, T_KEY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
